// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver (16x oversampled) feeding a first-word-fall-through byte FIFO.
// Optional interrupt output is built when UART_RX_IRQ_EN is defined.
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 8000000,
  parameter int BAUD        = 9600,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_UART_TX,
  input  logic       i_rd_en,
  input  logic       i_status_rd,
`ifdef UART_RX_IRQ_EN
  input  logic       i_irq_enable,
  output logic       o_rx_irq,
`endif
  output logic [7:0] o_rx_data,
  output logic [7:0] o_rx_status
);

  localparam int DIV   = CLK_FREQ_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [2:0] {S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic                  r_tx_meta, r_tx_sync;
  logic [1:0]            r_rd_sync, r_st_sync;
  logic                  r_rd_prev, r_st_prev;
  logic [DIV_W-1:0]      r_div_cnt;
  state_t                r_state, w_state_next;
  logic [3:0]            r_tcnt, w_tcnt_next;
  logic [2:0]            r_bitcnt, w_bitcnt_next;
  logic [7:0]            r_shift, w_shift_next;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr, w_rptr_next;
  logic [DEPTH_LOG2:0]   r_count, w_count_next;
  logic [7:0]            r_data;
  logic                  r_ovr, r_fe;
  logic                  w_tick, w_push_req, w_frame_err;
  logic                  w_rd_fall, w_st_fall, w_full, w_avail;
  logic                  w_push, w_pop, w_ovr_set;

  // The serial line synchroniser resets high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_meta <= 1'b1;
      r_tx_sync <= 1'b1;
      r_rd_sync <= 2'b00;
      r_st_sync <= 2'b00;
      r_rd_prev <= 1'b0;
      r_st_prev <= 1'b0;
    end else begin
      r_tx_meta <= i_UART_TX;
      r_tx_sync <= r_tx_meta;
      r_rd_sync <= {r_rd_sync[0], i_rd_en};
      r_st_sync <= {r_st_sync[0], i_status_rd};
      r_rd_prev <= r_rd_sync[1];
      r_st_prev <= r_st_sync[1];
    end
  end

  assign w_rd_fall = r_rd_prev & ~r_rd_sync[1];
  assign w_st_fall = r_st_prev & ~r_st_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_WAIT_IDLE;
      r_tcnt   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_tcnt   <= w_tcnt_next;
      r_bitcnt <= w_bitcnt_next;
      r_shift  <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_tcnt_next   = r_tcnt;
    w_bitcnt_next = r_bitcnt;
    w_shift_next  = r_shift;
    w_push_req    = 1'b0;
    w_frame_err   = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_WAIT_IDLE: if (r_tx_sync) w_state_next = S_IDLE;
        S_IDLE: begin
          if (!r_tx_sync) begin
            w_state_next = S_START;
            w_tcnt_next  = '0;
          end
        end
        S_START: begin
          // Re-check mid start bit so short low glitches are rejected.
          if (r_tcnt == 4'd7) begin
            w_tcnt_next   = '0;
            w_bitcnt_next = '0;
            w_state_next  = r_tx_sync ? S_IDLE : S_DATA;
          end else begin
            w_tcnt_next = r_tcnt + 4'd1;
          end
        end
        S_DATA: begin
          if (r_tcnt == 4'd15) begin
            w_shift_next = {r_tx_sync, r_shift[7:1]};
            w_tcnt_next  = '0;
            if (r_bitcnt == 3'd7) w_state_next  = S_STOP;
            else                  w_bitcnt_next = r_bitcnt + 3'd1;
          end else begin
            w_tcnt_next = r_tcnt + 4'd1;
          end
        end
        S_STOP: begin
          if (r_tcnt == 4'd15) begin
            w_tcnt_next = '0;
            if (r_tx_sync) begin
              w_push_req   = 1'b1;
              w_state_next = S_IDLE;
            end else begin
              w_frame_err  = 1'b1;
              w_state_next = S_WAIT_IDLE;
            end
          end else begin
            w_tcnt_next = r_tcnt + 4'd1;
          end
        end
        default: w_state_next = S_WAIT_IDLE;
      endcase
    end
  end

  assign w_full    = (r_count == CNT_FULL);
  assign w_avail   = (r_count != '0);
  assign w_pop     = w_rd_fall & w_avail;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is then accepted.
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_ovr_set = w_push_req & w_full & ~w_pop;
  assign w_rptr_next = w_pop ? r_rptr + PTR_ONE : r_rptr;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CNT_ONE;
    else if (w_pop && !w_push) w_count_next = r_count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_ovr   <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      r_rptr  <= w_rptr_next;
      r_count <= w_count_next;
      // Head register: bypass the byte being written when it becomes the new head.
      if (w_count_next == '0)                  r_data <= '0;
      else if (w_push && r_wptr == w_rptr_next) r_data <= r_shift;
      else                                      r_data <= r_mem[w_rptr_next];
      if (w_ovr_set)      r_ovr <= 1'b1;
      else if (w_st_fall) r_ovr <= 1'b0;
      if (w_frame_err)    r_fe <= 1'b1;
      else if (w_st_fall) r_fe <= 1'b0;
    end
  end

  assign o_rx_data   = r_data;
  assign o_rx_status = {4'b0000, w_full, r_fe, r_ovr, w_avail};

`ifdef UART_RX_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= i_irq_enable & (w_avail | r_ovr | r_fe);
  end

  assign o_rx_irq = r_irq;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a byte-queue model of the receiver tracks
// every frame, CPU read and status read; DUT outputs are compared against it.
module tb_uart_rx_fifo;

  localparam int CLKF  = 700000;
  localparam int BAUDV = 9600;
  localparam int DIVV  = CLKF / (BAUDV * 16);
  localparam int BITC  = DIVV * 16;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       line = 1'b1;
  logic       rd = 1'b0;
  logic       srd = 1'b0;
  logic [7:0] rx_data, rx_status;
`ifdef UART_RX_IRQ_EN
  logic       irq_en = 1'b0;
  logic       irq;
`endif

  uart_rx_fifo #(.CLK_FREQ_HZ(CLKF), .BAUD(BAUDV), .DEPTH_LOG2(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_UART_TX   (line),
    .i_rd_en     (rd),
    .i_status_rd (srd),
`ifdef UART_RX_IRQ_EN
    .i_irq_enable(irq_en),
    .o_rx_irq    (irq),
`endif
    .o_rx_data   (rx_data),
    .o_rx_status (rx_status)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output-change monitor used to measure latencies and watch a window for glitches.
  logic [15:0] prev_obs = 16'h0000;
  int          last_change = 0;
  logic        watch = 1'b0;
  int          watch_bad = 0;
  always @(negedge clk) begin
    if ({rx_data, rx_status} !== prev_obs) last_change <= cyc;
    prev_obs <= {rx_data, rx_status};
    if (watch && rx_status !== 8'h01) watch_bad <= watch_bad + 1;
  end

  // Reference model
  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  logic       m_fe = 1'b0;

  function automatic logic [7:0] exp_status();
    return {4'b0000, q.size() == DEPTH, m_fe, m_ovr, q.size() != 0};
  endfunction

  function automatic logic [7:0] exp_data();
    return (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    line = 1'b0;
    wait_cyc(BITC);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      wait_cyc(BITC);
    end
    line = stop;
    wait_cyc(BITC);
    line = 1'b1;
    wait_cyc(BITC / 2);
    if (!stop)                  m_fe = 1'b1;
    else if (q.size() == DEPTH) m_ovr = 1'b1;
    else                        q.push_back(b);
  endtask

  task automatic cpu_read();
    rd = 1'b1;
    wait_cyc(4);
    rd = 1'b0;
    wait_cyc(8);
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic cpu_status_read();
    srd = 1'b1;
    wait_cyc(4);
    srd = 1'b0;
    wait_cyc(8);
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic test_reset();
    wait_cyc(3);
    n_vec++;
    if ({rx_data, rx_status} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_held: data/status got %h expected 0000", {rx_data, rx_status});
    end
    reset = 1'b0;
    wait_cyc(3);
    n_vec++;
    if ({rx_data, rx_status} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_release: data/status got %h expected 0000", {rx_data, rx_status});
    end
  endtask

  task automatic test_single();
    send_frame(8'h55, 1'b1);
    n_vec++;
    if (rx_data !== 8'h55 || rx_status !== 8'h01) begin
      n_err++;
      $display("FAIL single_rx: data %h status %h expected 55 01", rx_data, rx_status);
    end
    cpu_read();
    n_vec++;
    if (rx_data !== 8'h00 || rx_status !== 8'h00) begin
      n_err++;
      $display("FAIL single_pop: data %h status %h expected 00 00", rx_data, rx_status);
    end
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b1);
    n_vec++;
    if (rx_status !== exp_status() || rx_status !== 8'h09) begin
      n_err++;
      $display("FAIL fill_full: status %h expected %h", rx_status, exp_status());
    end
    send_frame(8'hAA, 1'b1);
    n_vec++;
    if (rx_status !== 8'h0B || rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL overrun: status %h data %h expected 0b 00", rx_status, rx_data);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++;
      if (rx_data !== exp_data()) begin
        n_err++;
        $display("FAIL drain_%0d: data %h expected %h", i, rx_data, exp_data());
      end
      cpu_read();
    end
    n_vec++;
    if (rx_status !== 8'h02 || rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL drained: status %h data %h expected 02 00", rx_status, rx_data);
    end
    cpu_status_read();
    n_vec++;
    if (rx_status !== 8'h00) begin
      n_err++;
      $display("FAIL ovr_clear: status %h expected 00", rx_status);
    end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0);
    n_vec++;
    if (rx_status !== 8'h04 || rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL framing: status %h data %h expected 04 00", rx_status, rx_data);
    end
    wait_cyc(BITC);
    cpu_status_read();
    n_vec++;
    if (rx_status !== 8'h00) begin
      n_err++;
      $display("FAIL fe_clear: status %h expected 00", rx_status);
    end
    send_frame(8'h81, 1'b1);
    n_vec++;
    if (rx_data !== 8'h81 || rx_status !== 8'h01) begin
      n_err++;
      $display("FAIL after_fe: data %h status %h expected 81 01", rx_data, rx_status);
    end
    cpu_read();
  endtask

  task automatic test_glitch();
    line = 1'b0;
    wait_cyc(BITC * 5 / 16);
    line = 1'b1;
    wait_cyc(3 * BITC);
    n_vec++;
    if (rx_status !== 8'h00 || rx_data !== 8'h00) begin
      n_err++;
      $display("FAIL glitch: status %h data %h expected 00 00", rx_status, rx_data);
    end
    send_frame(8'h7E, 1'b1);
    n_vec++;
    if (rx_data !== 8'h7E || rx_status !== 8'h01) begin
      n_err++;
      $display("FAIL after_glitch: data %h status %h expected 7e 01", rx_data, rx_status);
    end
    cpu_read();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    for (int i = 0; i < 16; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(b, stop);
      n_vec++;
      if (rx_data !== exp_data() || rx_status !== exp_status()) begin
        n_err++;
        $display("FAIL rand_rx_%0d: data %h status %h expected %h %h", i, rx_data, rx_status,
                 exp_data(), exp_status());
      end
      if ($urandom_range(0, 1) == 0) begin
        cpu_read();
        n_vec++;
        if (rx_data !== exp_data() || rx_status !== exp_status()) begin
          n_err++;
          $display("FAIL rand_rd_%0d: data %h status %h expected %h %h", i, rx_data, rx_status,
                   exp_data(), exp_status());
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        cpu_status_read();
        n_vec++;
        if (rx_status !== exp_status()) begin
          n_err++;
          $display("FAIL rand_st_%0d: status %h expected %h", i, rx_status, exp_status());
        end
      end
    end
    while (q.size() != 0) cpu_read();
    cpu_status_read();
    n_vec++;
    if (rx_data !== 8'h00 || rx_status !== 8'h00) begin
      n_err++;
      $display("FAIL rand_drain: data %h status %h expected 00 00", rx_data, rx_status);
    end
  endtask

  task automatic test_back_to_back();
    int cs1, cf, ls, lp, k, t_y, t_fall;
    cs1 = cyc;
    send_frame(8'h3A, 1'b1);
    ls = last_change - cs1;
    n_vec++;
    if (ls <= 9 * BITC || ls >= 10 * BITC || rx_data !== 8'h3A) begin
      n_err++;
      $display("FAIL rx_latency: %0d clk data %h expected 9..10 bit times, 3a", ls, rx_data);
    end
    send_frame(8'hC5, 1'b1);
    rd = 1'b1;
    wait_cyc(4);
    cf = cyc;
    rd = 1'b0;
    wait_cyc(10);
    void'(q.pop_front());
    lp = last_change - cf;
    n_vec++;
    if (lp < 1 || lp > 8 || rx_data !== 8'hC5) begin
      n_err++;
      $display("FAIL pop_latency: %0d clk data %h expected 1..8, c5", lp, rx_data);
    end
    // Same tick phase as the measured frame, so the push lands at a known cycle.
    k      = (cyc + 16 - cs1) / DIVV + 1;
    t_y    = cs1 + k * DIVV;
    t_fall = t_y + ls - lp;
    while (cyc < t_y) @(negedge clk);
    watch = 1'b1;
    fork
      send_frame(8'h96, 1'b1);
      begin
        while (cyc < t_fall - 6) @(negedge clk);
        rd = 1'b1;
        while (cyc < t_fall) @(negedge clk);
        rd = 1'b0;
      end
    join
    void'(q.pop_front());
    wait_cyc(4);
    watch = 1'b0;
    n_vec++;
    if (watch_bad != 0) begin
      n_err++;
      $display("FAIL simul_window: %0d samples with status != 01, expected 0", watch_bad);
    end
    n_vec++;
    if (rx_data !== exp_data() || rx_status !== exp_status()) begin
      n_err++;
      $display("FAIL simul_result: data %h status %h expected %h %h", rx_data, rx_status,
               exp_data(), exp_status());
    end
    n_vec++;
    if (last_change != t_y + ls) begin
      n_err++;
      $display("FAIL simul_edge: head changed at %0d expected %0d", last_change, t_y + ls);
    end
    cpu_read();
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h5A, 1'b1);
    n_vec++;
    if (rx_data !== 8'h5A) begin
      n_err++;
      $display("FAIL pre_reset: data %h expected 5a", rx_data);
    end
    line = 1'b0;
    wait_cyc(5 * BITC + BITC / 2);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    wait_cyc(2);
    n_vec++;
    if (rx_data !== 8'h00 || rx_status !== 8'h00) begin
      n_err++;
      $display("FAIL midframe_reset: data %h status %h expected 00 00", rx_data, rx_status);
    end
    wait_cyc(12 * BITC);
    n_vec++;
    if (rx_data !== 8'h00 || rx_status !== 8'h00) begin
      n_err++;
      $display("FAIL wait_idle_hold: data %h status %h expected 00 00", rx_data, rx_status);
    end
    line = 1'b1;
    wait_cyc(BITC);
    send_frame(8'hA5, 1'b1);
    n_vec++;
    if (rx_data !== 8'hA5 || rx_status !== 8'h01) begin
      n_err++;
      $display("FAIL after_reset_rx: data %h status %h expected a5 01", rx_data, rx_status);
    end
    cpu_read();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_overrun();
    test_framing();
    test_glitch();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
